// File: rtl/pre_if_stage.sv
// Pre-fetch stage ahead of IF: owns the fetch PC, issues one instruction
// fetch at a time on the SRAM-like bus, buffers the returned word with its
// PC and hands it to IF through the valid/allowin handshake.
// Taken branches redirect the PC and squash any wrong-path fetch in flight.
// Build option PFS_ADEF_CHK_EN: misaligned fetch PCs are not issued; the
// stage instead hands IF an address-error marker and the bus grows to 65 bits.
//
// state | meaning
// REQ   | request on the bus for pc_q, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// HOLD  | instruction buffered, waiting for IF to take it

module pre_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BR_BUS_WD = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BR_BUS_WD-1:0] br_bus,
    input  logic                 fs_allowin,
    output logic                 pfs_to_fs_valid,
`ifdef PFS_ADEF_CHK_EN
    output logic [64:0]          pfs_to_fs_bus,
`else
    output logic [63:0]          pfs_to_fs_bus,
`endif
    output logic                 inst_sram_req,
    output logic                 inst_sram_wr,
    output logic [1:0]           inst_sram_size,
    output logic [3:0]           inst_sram_wstrb,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic                 inst_sram_addr_ok,
    input  logic                 inst_sram_data_ok,
    input  logic [31:0]          inst_sram_rdata
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        cancel_q, cancel_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
`ifdef PFS_ADEF_CHK_EN
    logic        buf_adef_q, buf_adef_d;
`endif

    logic        br_taken;
    logic [31:0] br_target;
    logic        pc_ok;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

`ifdef PFS_ADEF_CHK_EN
    assign pc_ok = (pc_q[1:0] == 2'b00);
`else
    assign pc_ok = 1'b1;
`endif

    assign inst_sram_req   = (state_q == REQ) && pc_ok && !reset;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // The buffer is only ever full in HOLD; a taken branch squashes it at once.
    assign pfs_to_fs_valid = buf_valid_q && !br_taken && !reset;
`ifdef PFS_ADEF_CHK_EN
    assign pfs_to_fs_bus   = {buf_adef_q, buf_pc_q, buf_inst_q};
`else
    assign pfs_to_fs_bus   = {buf_pc_q, buf_inst_q};
`endif

    // Next-state logic: fetch sequencing, squash tracking and buffer loading.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        cancel_d    = cancel_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
`ifdef PFS_ADEF_CHK_EN
        buf_adef_d  = buf_adef_q;
`endif
        unique case (state_q)
            REQ: begin
                if (!pc_ok) begin
`ifdef PFS_ADEF_CHK_EN
                    if (!br_taken) begin
                        buf_valid_d = 1'b1;
                        buf_adef_d  = 1'b1;
                        buf_pc_d    = pc_q;
                        buf_inst_d  = 32'h0;
                        state_d     = HOLD;
                    end
`endif
                end else if (inst_sram_addr_ok) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    // A redirect in the accept cycle makes this fetch wrong-path.
                    cancel_d = br_taken;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok) begin
                    cancel_d = 1'b0;
                    state_d  = REQ;
                    if (!cancel_q && !br_taken) begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_pc_q;
                        buf_inst_d  = inst_sram_rdata;
`ifdef PFS_ADEF_CHK_EN
                        buf_adef_d  = 1'b0;
`endif
                        state_d     = HOLD;
                    end
                end else if (br_taken) begin
                    cancel_d = 1'b1;
                end
            end
            HOLD: begin
                if (br_taken || (pfs_to_fs_valid && fs_allowin)) begin
                    buf_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (br_taken) begin
            pc_d = br_target;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            cancel_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_inst_q  <= 32'h0;
`ifdef PFS_ADEF_CHK_EN
            buf_adef_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            cancel_q    <= cancel_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
`ifdef PFS_ADEF_CHK_EN
            buf_adef_q  <= buf_adef_d;
`endif
        end
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
Pre-fetch (PF) stage directly upstream of the IF stage. Owns the fetch PC and drives the instruction memory through an SRAM-like request/address-ok/data-ok bus with at most one outstanding request. It buffers each returned instruction with its PC and hands it to IF through the valid/allowin handshake. It redirects on the branch bus and discards any in-flight wrong-path fetch.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
BR_BUS_WD, 33, branch bus width {br_taken, br_target[31:0]}

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
br_bus  input  BR_BUS_WD  {br_taken, br_target}; br_taken is a one-cycle pulse
fs_allowin  input  1  IF stage can accept this cycle
pfs_to_fs_valid  output  1  buffered instruction valid toward IF
pfs_to_fs_bus  output  64  {pc[31:0], inst[31:0]}
inst_sram_req  output  1  fetch request
inst_sram_wr  output  1  constant 0
inst_sram_size  output  2  constant 2'd2 (word)
inst_sram_wstrb  output  4  constant 0
inst_sram_addr  output  32  fetch address
inst_sram_wdata  output  32  constant 0
inst_sram_addr_ok  input  1  request accepted this cycle
inst_sram_data_ok  input  1  read data returned this cycle
inst_sram_rdata  input  32  read data

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- State registers: pc, req_pc, 3-state FSM {REQ, WAIT, HOLD}, cancel flag, buf_valid, buf_pc, buf_inst.
- Reset values: FSM=REQ, pc=RESET_PC, cancel=0, buf_valid=0, buf_pc=0, buf_inst=0.
- While reset is high: inst_sram_req=0 and pfs_to_fs_valid=0.
- inst_sram_req = (FSM==REQ) && !reset. inst_sram_addr = pc, driven combinationally.
- REQ:
  - addr_ok=1: req_pc<=pc; pc<=pc+4 (mod 2^32, wraps); go WAIT.
  - Otherwise stay in REQ. Address may change while unaccepted (on redirect only).
- WAIT:
  - data_ok=1, cancel=0: buf_valid<=1, buf_pc<=req_pc, buf_inst<=rdata; go HOLD.
  - data_ok=1, cancel=1: drop the data, cancel<=0, go REQ.
- HOLD:
  - pfs_to_fs_valid = buf_valid && !br_taken.
  - When pfs_to_fs_valid && fs_allowin: buf_valid<=0, go REQ.
  - Otherwise the buffer and bus hold stable.
- Latency: at least 3 cycles per instruction (REQ → WAIT → HOLD). The buffer is always empty in REQ and WAIT. data_ok outside WAIT is ignored.
- Redirect (br_taken=1): pc<=br_target, overriding pc+4. Per-state effects:
  - REQ, no addr_ok: request dropped; next cycle req=1 with addr=br_target.
  - REQ with addr_ok in the same cycle: go WAIT with cancel<=1 and req_pc ignored.
  - WAIT, no data_ok: cancel<=1.
  - WAIT with data_ok in the same cycle: drop the data, go REQ, cancel stays 0.
  - HOLD: buf_valid<=0, go REQ. pfs_to_fs_valid is forced 0 in that cycle.
- A second br_taken while cancel=1 only updates pc; cancel stays 1 (single outstanding request).
- Reset mid-operation returns to the reset state immediately. Any outstanding response is not expected, because memory is reset with the core.

Optional Feature:
Macro PFS_ADEF_CHK_EN.
- Defined:
  - pfs_to_fs_bus widens to 65 bits {adef, pc, inst}.
  - In REQ with pc[1:0]!=0: no request issued (req=0). Buffer loads adef=1, buf_pc=pc, inst=0; go HOLD.
  - Handshake and redirect rules are unchanged. Normal fetches carry adef=0.
- Undefined: 64-bit bus and no alignment check. The address is issued as-is.

Test Plan:
1. Reset 3 cycles, then release; addr_ok immediate; data_ok next cycle with rdata=0x02800000; fs_allowin=1 → first req addr=0x1c000000; pfs_to_fs_valid=1 with bus {0x1c000000, 0x02800000}; next req addr=0x1c000004.
2. Instruction buffered, fs_allowin=0 for 5 cycles → valid stays 1, bus stable, req=0 throughout; after fs_allowin=1, the next req is issued the following cycle.
3. br_taken target=0x1c000100 while in WAIT; data_ok 2 cycles later → returned data dropped, no valid toward IF; next req addr=0x1c000100.
4. br_taken coincident with data_ok in WAIT → data dropped, cancel not set; next cycle req addr=br_target; the following response is delivered normally.
5. addr_ok held low 3 cycles; br_taken to 0x1c000200 in the 2nd cycle → inst_sram_addr switches to 0x1c000200; accepted fetch returns with pc=0x1c000200; pc wraps 0xfffffffc → 0x00000000.
6. PFS_ADEF_CHK_EN: br_taken to 0x1c000102 → no req issued; valid=1 with bus {1, 0x1c000102, 0}.
